// File: rtl/vga_scan_ctrl.sv
// 640x480@60 VGA raster generator: pixel/line counters, syncs, blanking and registered RGB.
// Latency: h_addr/v_addr/valid/frame_tick are combinational from the counters; RGB, hsync, vsync and blank_n lag them by 1 pclk.
// Backpressure: none, the raster free-runs. Optional colour-bar generator when VGA_SCAN_TESTBAR_EN is defined.
module vga_scan_ctrl #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_LEN   = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_LEN   = 480
) (
    input  logic        pclk,
    input  logic        reset,
`ifdef VGA_SCAN_TESTBAR_EN
    input  logic        test_en,
`endif
    input  logic [23:0] vga_data,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic        valid,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        blank_n,
    output logic        frame_tick,
    output logic [7:0]  frame_cnt
);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_E = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_E = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_LO = 10'(H_ACT_START);
    localparam logic [9:0] H_ACT_HI = 10'(H_ACT_START + H_ACT_LEN);
    localparam logic [9:0] V_ACT_LO = 10'(V_ACT_START);
    localparam logic [9:0] V_ACT_HI = 10'(V_ACT_START + V_ACT_LEN);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        h_act;
    logic        v_act;
    logic        hsync_raw;
    logic        vsync_raw;
    logic [23:0] pix;

    always_comb begin
        h_act      = (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI);
        v_act      = (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);
        hsync_raw  = (h_cnt >= H_SYNC_E);
        vsync_raw  = (v_cnt >= V_SYNC_E);
        valid      = h_act && v_act;
        h_addr     = valid ? (h_cnt - H_ACT_LO) : 10'd0;
        v_addr     = valid ? (v_cnt - V_ACT_LO) : 10'd0;
        frame_tick = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end

`ifdef VGA_SCAN_TESTBAR_EN
    logic [2:0]  bar_idx;
    logic [23:0] bar_rgb;

    // Eight 80-column bars across the visible line.
    always_comb begin
        bar_idx = 3'(h_addr / 10'd80);
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
        pix = test_en ? bar_rgb : vga_data;
    end
`else
    assign pix = vga_data;
`endif

    always_ff @(posedge pclk) begin
        if (reset) begin
            h_cnt     <= 10'd0;
            v_cnt     <= 10'd0;
            frame_cnt <= 8'd0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            blank_n   <= 1'b0;
            vga_r     <= 8'd0;
            vga_g     <= 8'd0;
            vga_b     <= 8'd0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= 10'd0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
            if (frame_tick)
                frame_cnt <= frame_cnt + 8'd1;
            // Syncs and blanking share the RGB pipeline stage so they stay aligned at the DAC.
            hsync   <= hsync_raw;
            vsync   <= vsync_raw;
            blank_n <= valid;
            {vga_r, vga_g, vga_b} <= valid ? pix : 24'h000000;
        end
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: a full-size instance for line timing and pixel path, and a
// shrunken-raster instance so whole frames and the 256-frame counter wrap fit in a short run.
module tb_vga_scan_ctrl;

    logic pclk = 1'b0;
    always #20 pclk = ~pclk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- full-size instance ----------------
    logic        rst_a;
    logic        ff_mode_a;
    logic [23:0] data_a;
    logic [9:0]  h_addr_a, v_addr_a;
    logic        valid_a, hsync_a, vsync_a, blank_n_a, frame_tick_a;
    logic [7:0]  r_a, g_a, b_a, frame_cnt_a;
`ifdef VGA_SCAN_TESTBAR_EN
    logic        test_en_a = 1'b0;
`endif

    // Pixel source: address-derived pattern, or solid white.
    always_comb data_a = ff_mode_a ? 24'hFFFFFF : {6'b0, h_addr_a[9:2], v_addr_a};

    vga_scan_ctrl dut_a (
        .pclk(pclk), .reset(rst_a),
`ifdef VGA_SCAN_TESTBAR_EN
        .test_en(test_en_a),
`endif
        .vga_data(data_a), .h_addr(h_addr_a), .v_addr(v_addr_a), .valid(valid_a),
        .hsync(hsync_a), .vsync(vsync_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .blank_n(blank_n_a), .frame_tick(frame_tick_a), .frame_cnt(frame_cnt_a)
    );

    // ---------------- shrunken instance: 16x8 raster, 10x5 visible ----------------
    logic        rst_b;
    logic [23:0] data_b;
    logic [9:0]  h_addr_b, v_addr_b;
    logic        valid_b, hsync_b, vsync_b, blank_n_b, frame_tick_b;
    logic [7:0]  r_b, g_b, b_b, frame_cnt_b;
`ifdef VGA_SCAN_TESTBAR_EN
    logic        test_en_b = 1'b0;
`endif
    assign data_b = 24'hFFFFFF;

    vga_scan_ctrl #(
        .H_TOTAL(16), .H_SYNC(2), .H_ACT_START(4), .H_ACT_LEN(10),
        .V_TOTAL(8),  .V_SYNC(1), .V_ACT_START(2), .V_ACT_LEN(5)
    ) dut_b (
        .pclk(pclk), .reset(rst_b),
`ifdef VGA_SCAN_TESTBAR_EN
        .test_en(test_en_b),
`endif
        .vga_data(data_b), .h_addr(h_addr_b), .v_addr(v_addr_b), .valid(valid_b),
        .hsync(hsync_b), .vsync(vsync_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .blank_n(blank_n_b), .frame_tick(frame_tick_b), .frame_cnt(frame_cnt_b)
    );

    // ---------------- reference model state for instance A ----------------
    int ca = 0;
    int err_a = 0;
    int hs_fall1 = -1, hs_fall2 = -1, hs_rise1 = -1, vs_fall1 = -1, vs_rise1 = -1;
    int line35_valid = 0, line35_blank = 0;
    logic hs_prev = 1'b1, vs_prev = 1'b1;

    function automatic logic act_a(input int c);
        int hc, vc;
        hc = c % 800;
        vc = (c / 800) % 525;
        return (hc >= 144) && (hc < 784) && (vc >= 35) && (vc < 515);
    endfunction

    task automatic step_a();
        int hc, vc, ph, pv;
        logic e_hs, e_vs, e_bn, e_v;
        @(negedge pclk);
        ca++;
        hc = ca % 800;
        vc = (ca / 800) % 525;
        ph = (ca - 1) % 800;
        pv = ((ca - 1) / 800) % 525;
        e_hs = (ph >= 96);
        e_vs = (pv >= 2);
        e_bn = act_a(ca - 1);
        e_v  = act_a(ca);
        if (hsync_a !== e_hs || vsync_a !== e_vs || blank_n_a !== e_bn || valid_a !== e_v) err_a++;
        if (e_v && (h_addr_a !== 10'(hc - 144) || v_addr_a !== 10'(vc - 35))) err_a++;
        if (!e_v && (h_addr_a !== 10'd0 || v_addr_a !== 10'd0)) err_a++;
        if (frame_tick_a !== 1'b0 || frame_cnt_a !== 8'd0) err_a++;
        if (!blank_n_a && {r_a, g_a, b_a} !== 24'h0) err_a++;
        if (hs_prev && !hsync_a) begin
            if (hs_fall1 < 0) hs_fall1 = ca;
            else if (hs_fall2 < 0) hs_fall2 = ca;
        end
        if (!hs_prev && hsync_a && hs_rise1 < 0) hs_rise1 = ca;
        if (vs_prev && !vsync_a && vs_fall1 < 0) vs_fall1 = ca;
        if (!vs_prev && vsync_a && vs_rise1 < 0) vs_rise1 = ca;
        hs_prev = hsync_a;
        vs_prev = vsync_a;
        if (vc == 35 && valid_a) line35_valid++;
        if (pv == 35 && blank_n_a) line35_blank++;
    endtask

    task automatic advance_a(input int target);
        while (ca < target) step_a();
    endtask

    typedef struct {
        int          cyc;
        logic        ff;
        logic [9:0]  ha;
        logic [9:0]  va;
        logic        vld;
        logic        hs;
        logic        vs;
        logic        bn;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int cyc, input logic ff, input logic [9:0] ha, input logic [9:0] va,
                                input logic vld, input logic hs, input logic vs, input logic bn,
                                input logic [23:0] rgb);
        vec_t v;
        v.cyc = cyc; v.ff = ff; v.ha = ha; v.va = va; v.vld = vld;
        v.hs = hs; v.vs = vs; v.bn = bn; v.rgb = rgb;
        return v;
    endfunction

    task automatic run_a();
        vecs.push_back(mk(0,     0, 0,   0, 0, 1, 1, 0, 24'h000000));
        vecs.push_back(mk(1,     0, 0,   0, 0, 0, 0, 0, 24'h000000));
        vecs.push_back(mk(96,    0, 0,   0, 0, 0, 0, 0, 24'h000000));
        vecs.push_back(mk(97,    0, 0,   0, 0, 1, 0, 0, 24'h000000));
        vecs.push_back(mk(144,   0, 0,   0, 0, 1, 0, 0, 24'h000000));
        vecs.push_back(mk(800,   0, 0,   0, 0, 1, 0, 0, 24'h000000));
        vecs.push_back(mk(801,   0, 0,   0, 0, 0, 0, 0, 24'h000000));
        vecs.push_back(mk(1600,  0, 0,   0, 0, 1, 0, 0, 24'h000000));
        vecs.push_back(mk(1601,  0, 0,   0, 0, 0, 1, 0, 24'h000000));
        vecs.push_back(mk(28144, 0, 0,   0, 1, 1, 1, 0, 24'h000000));
        vecs.push_back(mk(28150, 0, 6,   0, 1, 1, 1, 1, 24'h000400));
        vecs.push_back(mk(28783, 0, 639, 0, 1, 1, 1, 1, 24'h027C00));
        vecs.push_back(mk(28784, 0, 0,   0, 0, 1, 1, 1, 24'h027C00));
        vecs.push_back(mk(28785, 0, 0,   0, 0, 1, 1, 0, 24'h000000));
        vecs.push_back(mk(29584, 0, 0,   0, 0, 1, 1, 1, 24'h027C01));
        vecs.push_back(mk(29585, 0, 0,   0, 0, 1, 1, 0, 24'h000000));
        vecs.push_back(mk(29610, 1, 0,   0, 0, 0, 1, 0, 24'h000000));
        vecs.push_back(mk(29745, 1, 1,   2, 1, 1, 1, 1, 24'hFFFFFF));
        vecs.push_back(mk(30385, 1, 0,   0, 0, 1, 1, 0, 24'h000000));
        vecs.push_back(mk(30400, 1, 0,   0, 0, 1, 1, 0, 24'h000000));

        rst_a = 1'b1;
        ff_mode_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check($sformatf("a_rst%0d_hsync", i), hsync_a, 1'b1);
            check($sformatf("a_rst%0d_vsync", i), vsync_a, 1'b1);
            check($sformatf("a_rst%0d_rgb", i), {r_a, g_a, b_a}, 24'h0);
        end
        rst_a = 1'b0;
        ca = 0;
        check("a_rel_frame_tick", frame_tick_a, 1'b0);

        foreach (vecs[i]) begin
            ff_mode_a = vecs[i].ff;
            advance_a(vecs[i].cyc);
            check($sformatf("v%0d_c%0d_h_addr", i, vecs[i].cyc), h_addr_a, vecs[i].ha);
            check($sformatf("v%0d_c%0d_v_addr", i, vecs[i].cyc), v_addr_a, vecs[i].va);
            check($sformatf("v%0d_c%0d_valid", i, vecs[i].cyc), valid_a, vecs[i].vld);
            check($sformatf("v%0d_c%0d_hsync", i, vecs[i].cyc), hsync_a, vecs[i].hs);
            check($sformatf("v%0d_c%0d_vsync", i, vecs[i].cyc), vsync_a, vecs[i].vs);
            check($sformatf("v%0d_c%0d_blank_n", i, vecs[i].cyc), blank_n_a, vecs[i].bn);
            check($sformatf("v%0d_c%0d_rgb", i, vecs[i].cyc), {r_a, g_a, b_a}, vecs[i].rgb);
        end

`ifdef VGA_SCAN_TESTBAR_EN
        advance_a(30600);
        test_en_a = 1'b1;
        advance_a(30623);
        check("bar_h79_addr", h_addr_a, 10'd79);
        advance_a(30624);
        check("bar_h80_addr", h_addr_a, 10'd80);
        check("bar_h79_rgb", {r_a, g_a, b_a}, 24'hFFFFFF);
        advance_a(30625);
        check("bar_h80_rgb", {r_a, g_a, b_a}, 24'hFFFF00);
        advance_a(30704);
        check("bar_h159_rgb", {r_a, g_a, b_a}, 24'hFFFF00);
        advance_a(30705);
        check("bar_h160_rgb", {r_a, g_a, b_a}, 24'h00FFFF);
        advance_a(31183);
        check("bar_h639_addr", h_addr_a, 10'd639);
        advance_a(31184);
        check("bar_h639_rgb", {r_a, g_a, b_a}, 24'h000000);
        check("bar_h639_blank_n", blank_n_a, 1'b1);
        advance_a(31185);
        check("bar_blank_rgb", {r_a, g_a, b_a}, 24'h000000);
        test_en_a = 1'b0;
`endif

        check("a_model_errors", err_a, 0);
        check("a_hsync_first_fall", hs_fall1, 1);
        check("a_hsync_low_width", hs_rise1 - hs_fall1, 96);
        check("a_hsync_period", hs_fall2 - hs_fall1, 800);
        check("a_vsync_low_width", vs_rise1 - vs_fall1, 1600);
        check("a_line35_valid_cnt", line35_valid, 640);
        check("a_line35_blank_cnt", line35_blank, 640);
    endtask

    // ---------------- reference model state for instance B ----------------
    localparam int NB = 128;
    int cb = 0;
    int err_b = 0;
    int first_tick = -1, last_tick = -1, tick_cnt = 0;
    int f0_vs_low = 0, f0_valid = 0, f0_blank = 0;
    logic phase1 = 1'b1;

    task automatic step_b();
        int hc, vc;
        logic e_tick, e_v;
        @(negedge pclk);
        cb++;
        hc = cb % 16;
        vc = (cb / 16) % 8;
        e_tick = (cb % NB) == NB - 1;
        e_v = (hc >= 4) && (hc < 14) && (vc >= 2) && (vc < 7);
        if (frame_tick_b !== e_tick) err_b++;
        if (valid_b !== e_v) err_b++;
        if (e_v && (h_addr_b !== 10'(hc - 4) || v_addr_b !== 10'(vc - 2))) err_b++;
        if (frame_cnt_b !== 8'((cb / NB) % 256)) err_b++;
        if (!blank_n_b && {r_b, g_b, b_b} !== 24'h0) err_b++;
        if (blank_n_b && {r_b, g_b, b_b} !== 24'hFFFFFF) err_b++;
        if (frame_tick_b) begin
            tick_cnt++;
            if (first_tick < 0) first_tick = cb;
            if (last_tick >= 0 && cb - last_tick != NB) err_b++;
            last_tick = cb;
        end
        if (phase1 && cb <= NB) begin
            if (!vsync_b) f0_vs_low++;
            if (blank_n_b) f0_blank++;
            if (valid_b && cb < NB) f0_valid++;
        end
    endtask

    task automatic run_b();
        rst_b = 1'b1;
        repeat (3) @(negedge pclk);
        check("b_rst_hsync", hsync_b, 1'b1);
        check("b_rst_vsync", vsync_b, 1'b1);
        check("b_rst_blank_n", blank_n_b, 1'b0);
        check("b_rst_frame_cnt", frame_cnt_b, 8'd0);
        rst_b = 1'b0;
        cb = 0;

        while (cb < 256 * NB - 1) step_b();
        check("b_tick256", frame_tick_b, 1'b1);
        check("b_frame_cnt_pre_wrap", frame_cnt_b, 8'd255);
        step_b();
        check("b_frame_cnt_wrap", frame_cnt_b, 8'd0);
        check("b_tick_count", tick_cnt, 256);
        check("b_first_tick", first_tick, NB - 1);
        check("b_f0_vsync_low", f0_vs_low, 16);
        check("b_f0_valid_cnt", f0_valid, 50);
        check("b_f0_blank_cnt", f0_blank, 50);

        // Abort mid-frame in the visible region, then expect a clean restart.
        while (!((cb % 16) == 7 && ((cb / 16) % 8) == 4)) step_b();
        check("b_pre_abort_valid", valid_b, 1'b1);
        rst_b = 1'b1;
        @(negedge pclk);
        check("b_abort_valid", valid_b, 1'b0);
        check("b_abort_h_addr", h_addr_b, 10'd0);
        check("b_abort_hsync", hsync_b, 1'b1);
        check("b_abort_rgb", {r_b, g_b, b_b}, 24'h0);
        check("b_abort_frame_cnt", frame_cnt_b, 8'd0);
        @(negedge pclk);
        rst_b = 1'b0;
        phase1 = 1'b0;
        cb = 0;
        first_tick = -1;
        last_tick = -1;
        tick_cnt = 0;
        while (cb < NB + 2) step_b();
        check("b_restart_first_tick", first_tick, NB - 1);
        check("b_restart_tick_count", tick_cnt, 1);
        check("b_restart_frame_cnt", frame_cnt_b, 8'd1);
        check("b_model_errors", err_b, 0);
    endtask

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
